modn_updown_counter: RTL and testbench



---
 rtl/modn_updown_counter.sv | 66 ++++++
 tb/tb_modn_updown_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/modn_updown_counter.sv
// Modulo-MODULUS up/down counter with clear, parallel load and a combinational cascade pulse.
// Latency: count, wrap_q and load_err update 1 cycle after the edge; next is combinational.
// Backpressure: none; en is the only advance qualifier and next feeds the following stage's en.
module modn_updown_counter #(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             next,
    output logic             wrap_q,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);

    logic             at_top;
    logic             at_zero;
    logic             load_ok;
    logic [WIDTH-1:0] step;

    always_comb begin
        at_top  = (count == CNT_MAX);
        at_zero = (count == '0);
        load_ok = ({1'b0, load_val} < MOD_W);
        next    = !rst && en && !clr && !load && (up_dn ? at_top : at_zero);
        step    = count;
        if (up_dn) begin
            step = at_top ? '0 : count + WIDTH'(1);
        end else begin
            step = at_zero ? CNT_MAX : count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            wrap_q   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap_q   <= next;
            load_err <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (load) begin
                // Out-of-range loads leave count untouched and flag for one cycle.
                if (load_ok) begin
                    count <= load_val;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                count <= step;
            end
        end
    end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: mod-60 instance, 60->24 chain, and mod-10/4-bit instance.
// Directed scenarios followed by random stimulus, all checked against an arithmetic model.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_modn_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // mod-60 instance
    logic       a_rst = 1'b1, a_en = 1'b0, a_clr = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [5:0] a_lv = '0;
    logic [5:0] a_count;
    logic       a_next, a_wrap, a_err;

    // seconds (mod 60) -> hours-style (mod 24) chain
    logic       c_rst = 1'b1, c_en = 1'b0, c_clr = 1'b0, c_up = 1'b1;
    logic       lo_load = 1'b0, hi_load = 1'b0;
    logic [5:0] lo_lv = '0;
    logic [4:0] hi_lv = '0;
    logic [5:0] lo_count;
    logic [4:0] hi_count;
    logic       lo_next, lo_wrap, lo_err, hi_next, hi_wrap, hi_err;

    // mod-10, 4-bit instance
    logic       d_rst = 1'b1, d_en = 1'b0, d_clr = 1'b0, d_up = 1'b1, d_load = 1'b0;
    logic [3:0] d_lv = '0;
    logic [3:0] d_count;
    logic       d_next, d_wrap, d_err;

    modn_updown_counter #(.WIDTH(6), .MODULUS(60)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .clr(a_clr), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .count(a_count), .next(a_next), .wrap_q(a_wrap), .load_err(a_err)
    );

    modn_updown_counter #(.WIDTH(6), .MODULUS(60)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .clr(c_clr), .up_dn(c_up), .load(lo_load),
        .load_val(lo_lv), .count(lo_count), .next(lo_next), .wrap_q(lo_wrap), .load_err(lo_err)
    );

    modn_updown_counter #(.WIDTH(5), .MODULUS(24)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_next), .clr(c_clr), .up_dn(c_up), .load(hi_load),
        .load_val(hi_lv), .count(hi_count), .next(hi_next), .wrap_q(hi_wrap), .load_err(hi_err)
    );

    modn_updown_counter #(.WIDTH(4), .MODULUS(10)) u_d (
        .clk(clk), .rst(d_rst), .en(d_en), .clr(d_clr), .up_dn(d_up), .load(d_load),
        .load_val(d_lv), .count(d_count), .next(d_next), .wrap_q(d_wrap), .load_err(d_err)
    );

    // Model state (post-edge values expected on the outputs).
    int a_cnt = 0, a_wq = 0, a_er = 0;
    int l_cnt = 0, l_wq = 0, l_er = 0;
    int h_cnt = 0, h_wq = 0, h_er = 0;
    int m_cnt = 0, m_wq = 0, m_er = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Behaviour of one stage for one edge, in plain modular arithmetic.
    task automatic mdl(input int m, input logic rst, en, clr, up, load, input int lv,
                       input int cnt, output logic nxt, output int cnt_o, wq_o, er_o);
        int stepped;
        stepped = up ? cnt + 1 : cnt - 1;
        nxt = !rst && en && !clr && !load && (stepped >= m || stepped < 0);
        if (rst) begin
            cnt_o = 0; wq_o = 0; er_o = 0;
        end else begin
            wq_o  = int'(nxt);
            er_o  = int'(!clr && load && lv >= m);
            if (clr)       cnt_o = 0;
            else if (load) cnt_o = (lv < m) ? lv : cnt;
            else if (en)   cnt_o = (stepped + m) % m;
            else           cnt_o = cnt;
        end
    endtask

    task automatic cycle();
        logic nx_a, nx_l, nx_h, nx_d;
        int c, w, e;
        #1;
        mdl(60, a_rst, a_en, a_clr, a_up, a_load, int'(a_lv), a_cnt, nx_a, c, w, e);
        chk("a_count", int'(a_count), a_cnt);
        chk("a_next",  int'(a_next),  int'(nx_a));
        chk("a_wrap",  int'(a_wrap),  a_wq);
        chk("a_err",   int'(a_err),   a_er);
        a_cnt = c; a_wq = w; a_er = e;

        mdl(60, c_rst, c_en, c_clr, c_up, lo_load, int'(lo_lv), l_cnt, nx_l, c, w, e);
        chk("lo_count", int'(lo_count), l_cnt);
        chk("lo_next",  int'(lo_next),  int'(nx_l));
        chk("lo_wrap",  int'(lo_wrap),  l_wq);
        chk("lo_err",   int'(lo_err),   l_er);
        l_cnt = c; l_wq = w; l_er = e;
        mdl(24, c_rst, nx_l, c_clr, c_up, hi_load, int'(hi_lv), h_cnt, nx_h, c, w, e);
        chk("hi_count", int'(hi_count), h_cnt);
        chk("hi_next",  int'(hi_next),  int'(nx_h));
        chk("hi_wrap",  int'(hi_wrap),  h_wq);
        chk("hi_err",   int'(hi_err),   h_er);
        h_cnt = c; h_wq = w; h_er = e;

        mdl(10, d_rst, d_en, d_clr, d_up, d_load, int'(d_lv), m_cnt, nx_d, c, w, e);
        chk("d_count", int'(d_count), m_cnt);
        chk("d_next",  int'(d_next),  int'(nx_d));
        chk("d_wrap",  int'(d_wrap),  m_wq);
        chk("d_err",   int'(d_err),   m_er);
        chk("d_range", int'(d_count < 4'd10), 1);
        m_cnt = c; m_wq = w; m_er = e;

        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        @(negedge clk);
        #1;
        run(2);
        a_rst = 1'b0; c_rst = 1'b0; d_rst = 1'b0;

        // Up-count through a full mod-60 wrap.
        a_en = 1'b1; a_up = 1'b1;
        run(62);

        // Down-count from reset: 0 -> 59 -> 58 ...
        a_rst = 1'b1; run(1);
        a_rst = 1'b0; a_up = 1'b0; run(4);

        // Accepted then rejected load.
        a_en = 1'b0; a_load = 1'b1; a_lv = 6'd45; run(1);
        a_lv = 6'd60; run(1);
        a_load = 1'b0; run(2);

        // Clear and load both override a wrapping increment.
        a_load = 1'b1; a_lv = 6'd59; run(1);
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b1; a_clr = 1'b1; run(1);
        a_clr = 1'b0; a_load = 1'b1; a_lv = 6'd59; a_en = 1'b0; run(1);
        a_en = 1'b1; a_lv = 6'd10; run(1);
        a_load = 1'b0; run(1);

        // Direction flip at the top value: decrement, no cascade.
        a_load = 1'b1; a_lv = 6'd59; a_en = 1'b0; run(1);
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b0; run(2);
        a_en = 1'b0;

        // Chain: 23:59 -> 00:00 on one edge.
        lo_load = 1'b1; lo_lv = 6'd59; hi_load = 1'b1; hi_lv = 5'd23; run(1);
        lo_load = 1'b0; hi_load = 1'b0; c_en = 1'b1; c_up = 1'b1; run(3);
        c_en = 1'b0; run(1);
        chk("chain_hh", int'(hi_count), 0);
        chk("chain_ss", int'(lo_count), 2);

        // Mod-10: reset at count 7, then resume.
        d_en = 1'b1; d_up = 1'b1; run(7);
        d_rst = 1'b1; run(1);
        d_rst = 1'b0; run(25);

        // Randomized traffic on all instances.
        for (int i = 0; i < 2000; i++) begin
            a_rst  = ($urandom_range(63) == 0);
            a_clr  = ($urandom_range(15) == 0);
            a_load = ($urandom_range(7) == 0);
            a_en   = ($urandom_range(3) != 0);
            a_up   = ($urandom_range(1) != 0);
            a_lv   = 6'($urandom);
            c_rst  = ($urandom_range(127) == 0);
            c_clr  = ($urandom_range(31) == 0);
            c_en   = ($urandom_range(7) != 0);
            c_up   = ($urandom_range(7) != 0);
            lo_load = ($urandom_range(15) == 0);
            hi_load = ($urandom_range(15) == 0);
            lo_lv  = 6'($urandom);
            hi_lv  = 5'($urandom);
            d_rst  = ($urandom_range(63) == 0);
            d_clr  = ($urandom_range(15) == 0);
            d_load = ($urandom_range(7) == 0);
            d_en   = ($urandom_range(3) != 0);
            d_up   = ($urandom_range(1) != 0);
            d_lv   = 4'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
